// File: rtl/digit_entry_fsm_pkg.sv
// Shared definitions for the digit-entry controller.
//   state_t    : controller state (EMPTY / ENTRY / FULL), 2-bit encoding;
//                the fourth code is unused and is recovered from.
//   BLANK_CODE : default code for an unfilled slot (the decoder shows blank).
//   BCD_MAX    : largest digit value accepted on bcd_in.
//   state_for  : state implied by a given fill count.
package digit_entry_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  function automatic state_t state_for(input int unsigned cnt, input int unsigned n);
    if (cnt == 0)
      return ST_EMPTY;
    else if (cnt >= n)
      return ST_FULL;
    else
      return ST_ENTRY;
  endfunction

endpackage

// File: rtl/digit_entry_fsm_if.sv
// Bundle of signals between the switch/button front end and the digit-entry
// controller.
//   bcd_in, enter, bksp, clr : from the debounced inputs (master drives)
//   digits, count, full      : registered slot bank and fill status
//   done, err                : one-cycle event pulses
//   state                    : controller state, exported for debug/checkers
//
// Press semantics: there is no valid/ready handshake. enter and bksp are level
// buttons; an operation is requested only on a 0->1 transition, sampled at
// clk. bcd_in is sampled on the same clock as the enter transition. clr is a
// level and acts on every cycle it is high. The controller never stalls.
interface digit_entry_if #(
  parameter int NUM_DIGITS = 4
) ();
  import digit_entry_pkg::*;

  logic [3:0]                        bcd_in;
  logic                              enter;
  logic                              bksp;
  logic                              clr;
  logic [4*NUM_DIGITS-1:0]           digits;
  logic [$clog2(NUM_DIGITS+1)-1:0]   count;
  logic                              full;
  logic                              done;
  logic                              err;
  state_t                            state;

  modport master (
    output bcd_in, enter, bksp, clr,
    input  digits, count, full, done, err, state
  );

  modport slave (
    input  bcd_in, enter, bksp, clr,
    output digits, count, full, done, err, state
  );

endinterface

// File: rtl/digit_entry_fsm_rise_detect.sv
// Rising-edge detector for a debounced level button.
//   clk, rst : clock and synchronous active-high reset
//   level    : button level
//   rise     : high for the cycle in which level is first seen high
// While rst is high the history register follows the live level, so it is 0
// for a released button, and a button held through reset reads as "already
// high" afterwards: it must be released and pressed again to produce a rise.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    level_q <= level;
  end

  // Reset only masks the output; the history register keeps tracking.
  assign rise = level & ~level_q & ~rst;

endmodule

// File: rtl/digit_entry_fsm.sv
// Digit-entry controller: captures up to NUM_DIGITS BCD digits, one per enter
// press, into an ordered slot bank for the seven-segment display path.
// Supports backspace, clear, BCD validation, full/done signalling and a
// selectable policy for presses while full (WRAP=1 restart, WRAP=0 reject).
//   clk, rst : clock and synchronous active-high reset
//   bus      : digit_entry_if slave (inputs bcd_in/enter/bksp/clr; outputs
//              digits/count/full/done/err/state)
// Slot 0 (first entered) sits in the most significant nibble of digits.
module digit_entry_fsm
  import digit_entry_pkg::*;
#(
  parameter int         NUM_DIGITS = 4,
  parameter bit         WRAP       = 1'b1,
  parameter logic [3:0] BLANK      = BLANK_CODE
) (
  input  logic          clk,
  input  logic          rst,
  digit_entry_if.slave  bus
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] N_C = CW'(NUM_DIGITS);

  logic enter_rise;
  logic bksp_rise;

  rise_detect u_enter_rise (.clk(clk), .rst(rst), .level(bus.enter), .rise(enter_rise));
  rise_detect u_bksp_rise  (.clk(clk), .rst(rst), .level(bus.bksp),  .rise(bksp_rise));

  state_t          state_q, state_d;
  logic [3:0]      slot_q [NUM_DIGITS];
  logic [3:0]      slot_d [NUM_DIGITS];
  logic [CW-1:0]   count_q, count_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) slot_q[i] <= BLANK;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
      for (int i = 0; i < NUM_DIGITS; i++) slot_q[i] <= slot_d[i];
    end
  end

  // Priority: clr, then enter, then backspace. Lower-priority requests in the
  // same cycle are dropped without flagging an error.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) slot_d[i] = slot_q[i];

    if (!(state_q inside {ST_EMPTY, ST_ENTRY, ST_FULL}) || bus.clr) begin
      // Unused encoding recovers the same way as a clear.
      state_d = ST_EMPTY;
      count_d = '0;
      for (int i = 0; i < NUM_DIGITS; i++) slot_d[i] = BLANK;
    end else if (enter_rise) begin
      if (bus.bcd_in > BCD_MAX) begin
        err_d = 1'b1;
      end else if (state_q != ST_FULL) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (CW'(i) == count_q) slot_d[i] = bus.bcd_in;
        count_d = count_q + CW'(1);
        state_d = state_for(32'(count_d), NUM_DIGITS);
        done_d  = (count_d == N_C);
      end else if (WRAP) begin
        for (int i = 1; i < NUM_DIGITS; i++) slot_d[i] = BLANK;
        slot_d[0] = bus.bcd_in;
        count_d   = CW'(1);
        state_d   = state_for(1, NUM_DIGITS);
        done_d    = (NUM_DIGITS == 1);
      end else begin
        err_d = 1'b1;
      end
    end else if (bksp_rise) begin
      if (count_q != '0) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (CW'(i) == count_q - CW'(1)) slot_d[i] = BLANK;
        count_d = count_q - CW'(1);
        state_d = state_for(32'(count_d), NUM_DIGITS);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    bus.digits = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      bus.digits[4*(NUM_DIGITS-k)-1 -: 4] = slot_q[k];
  end

  assign bus.count = count_q;
  assign bus.full  = (state_q == ST_FULL);
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_digit_entry_fsm.sv
// Bench for digit_entry_fsm: two instances (WRAP=1 and WRAP=0) share one set
// of inputs. A list-based model of the entry rules predicts both; a constant
// vector table and hand sequences pin down the documented scenarios.
module tb_digit_entry_fsm;
  import digit_entry_pkg::*;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] bcd_in = '0;
  logic       enter  = 1'b0;
  logic       bksp   = 1'b0;
  logic       clr    = 1'b0;

  digit_entry_if #(.NUM_DIGITS(N)) bus_w ();
  digit_entry_if #(.NUM_DIGITS(N)) bus_n ();

  assign bus_w.bcd_in = bcd_in;
  assign bus_w.enter  = enter;
  assign bus_w.bksp   = bksp;
  assign bus_w.clr    = clr;
  assign bus_n.bcd_in = bcd_in;
  assign bus_n.enter  = enter;
  assign bus_n.bksp   = bksp;
  assign bus_n.clr    = clr;

  digit_entry_fsm #(.NUM_DIGITS(N), .WRAP(1'b1), .BLANK(4'hF)) dut_w (
    .clk(clk), .rst(rst), .bus(bus_w));
  digit_entry_fsm #(.NUM_DIGITS(N), .WRAP(1'b0), .BLANK(4'hF)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 models the WRAP=1 instance, index 1 the WRAP=0 instance.
  // Each entry is an ordered list of the digits typed so far.
  int md [2][8];
  int mc [2];
  bit m_done [2];
  bit m_err  [2];
  bit prev_enter, prev_bksp;

  function automatic logic [4*N-1:0] model_digits(input int i);
    logic [4*N-1:0] v;
    for (int k = 0; k < N; k++)
      v[4*(N-k)-1 -: 4] = (k < mc[i]) ? 4'(md[i][k]) : 4'hF;
    return v;
  endfunction

  task automatic model_step(input logic [3:0] b, input bit e, input bit bk,
                            input bit c, input bit r);
    bit er, br;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        mc[i] = 0; m_done[i] = 0; m_err[i] = 0;
      end
      prev_enter = e;
      prev_bksp  = bk;
      return;
    end
    er = e && !prev_enter;
    br = bk && !prev_bksp;
    prev_enter = e;
    prev_bksp  = bk;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      m_err[i]  = 0;
      if (c) begin
        mc[i] = 0;
      end else if (er) begin
        if (int'(b) > 9) m_err[i] = 1;
        else if (mc[i] < N) begin
          md[i][mc[i]] = int'(b);
          mc[i]++;
          m_done[i] = (mc[i] == N);
        end else if (i == 0) begin
          md[i][0] = int'(b);
          mc[i] = 1;
          m_done[i] = (N == 1);
        end else begin
          m_err[i] = 1;
        end
      end else if (br) begin
        if (mc[i] > 0) mc[i]--;
        else m_err[i] = 1;
      end
    end
  endtask

  task automatic compare_model();
    check("w.digits", 64'(bus_w.digits), 64'(model_digits(0)));
    check("w.count",  64'(bus_w.count),  64'(mc[0]));
    check("w.full",   64'(bus_w.full),   64'(mc[0] == N));
    check("w.done",   64'(bus_w.done),   64'(m_done[0]));
    check("w.err",    64'(bus_w.err),    64'(m_err[0]));
    check("n.digits", 64'(bus_n.digits), 64'(model_digits(1)));
    check("n.count",  64'(bus_n.count),  64'(mc[1]));
    check("n.full",   64'(bus_n.full),   64'(mc[1] == N));
    check("n.done",   64'(bus_n.done),   64'(m_done[1]));
    check("n.err",    64'(bus_n.err),    64'(m_err[1]));
  endtask

  // ---------------- driver ----------------
  // Inputs change at the falling edge; outputs are sampled at the next one.
  task automatic tick(input logic [3:0] b, input bit e, input bit bk,
                      input bit c, input bit r);
    bcd_in = b; enter = e; bksp = bk; clr = c; rst = r;
    @(posedge clk);
    model_step(b, e, bk, c, r);
    @(negedge clk);
    compare_model();
  endtask

  task automatic press(input logic [3:0] b);
    tick(b, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(b, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- vector table (WRAP=1 instance) ----------------
  typedef struct {
    logic [3:0]     bcd;
    bit             e, bk, c;
    logic [4*N-1:0] dig;
    logic [CW-1:0]  cnt;
    bit             full, done, err;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic [3:0] b, input bit e, input bit bk, input bit c,
                     input logic [15:0] d, input int cnt, input bit f,
                     input bit dn, input bit er);
    vec_t v;
    v.bcd = b; v.e = e; v.bk = bk; v.c = c;
    v.dig = d; v.cnt = CW'(cnt); v.full = f; v.done = dn; v.err = er;
    tbl.push_back(v);
  endtask

  initial begin
    // press 1,2,3,4 -> full with one done pulse
    add(4'd1, 1, 0, 0, 16'h1FFF, 1, 0, 0, 0);
    add(4'd1, 0, 0, 0, 16'h1FFF, 1, 0, 0, 0);
    add(4'd2, 1, 0, 0, 16'h12FF, 2, 0, 0, 0);
    add(4'd2, 0, 0, 0, 16'h12FF, 2, 0, 0, 0);
    add(4'd3, 1, 0, 0, 16'h123F, 3, 0, 0, 0);
    add(4'd3, 0, 0, 0, 16'h123F, 3, 0, 0, 0);
    add(4'd4, 1, 0, 0, 16'h1234, 4, 1, 1, 0);
    add(4'd4, 0, 0, 0, 16'h1234, 4, 1, 0, 0);
    // press while full restarts entry
    add(4'd9, 1, 0, 0, 16'h9FFF, 1, 0, 0, 0);
    add(4'd9, 0, 0, 0, 16'h9FFF, 1, 0, 0, 0);
    // invalid BCD rejected
    add(4'hA, 1, 0, 0, 16'h9FFF, 1, 0, 0, 1);
    add(4'hA, 0, 0, 0, 16'h9FFF, 1, 0, 0, 0);
    // backspace to empty, then backspace on empty
    add(4'd0, 0, 1, 0, 16'hFFFF, 0, 0, 0, 0);
    add(4'd0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0);
    add(4'd0, 0, 1, 0, 16'hFFFF, 0, 0, 0, 1);
    add(4'd0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0);
    // 7,8 then backspace
    add(4'd7, 1, 0, 0, 16'h7FFF, 1, 0, 0, 0);
    add(4'd7, 0, 0, 0, 16'h7FFF, 1, 0, 0, 0);
    add(4'd8, 1, 0, 0, 16'h78FF, 2, 0, 0, 0);
    add(4'd8, 0, 0, 0, 16'h78FF, 2, 0, 0, 0);
    add(4'd0, 0, 1, 0, 16'h7FFF, 1, 0, 0, 0);
    add(4'd0, 0, 0, 0, 16'h7FFF, 1, 0, 0, 0);
    // enter, bksp and clr together: clr wins, no err
    add(4'd5, 1, 1, 1, 16'hFFFF, 0, 0, 0, 0);
    add(4'd5, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0);
    // enter and bksp together: enter wins, bksp dropped silently
    add(4'd3, 1, 1, 0, 16'h3FFF, 1, 0, 0, 0);
    add(4'd3, 0, 0, 0, 16'h3FFF, 1, 0, 0, 0);
  end

  // ---------------- test sequence ----------------
  initial begin
    int dones;
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0; m_done[i] = 0; m_err[i] = 0;
    end
    prev_enter = 0; prev_bksp = 0;

    @(negedge clk);
    tick(4'd0, 0, 0, 0, 1);
    tick(4'd0, 0, 0, 0, 1);
    check("reset.digits", 64'(bus_w.digits), 64'hFFFF);
    check("reset.count",  64'(bus_w.count),  64'd0);
    check("reset.full",   64'(bus_w.full),   64'd0);
    check("reset.done",   64'(bus_w.done),   64'd0);
    check("reset.err",    64'(bus_w.err),    64'd0);
    check("reset.state",  64'(bus_w.state),  64'(ST_EMPTY));
    tick(4'd0, 0, 0, 0, 0);

    // table
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].bcd, tbl[i].e, tbl[i].bk, tbl[i].c, 1'b0);
      check($sformatf("tbl%0d.digits", i), 64'(bus_w.digits), 64'(tbl[i].dig));
      check($sformatf("tbl%0d.count", i),  64'(bus_w.count),  64'(tbl[i].cnt));
      check($sformatf("tbl%0d.full", i),   64'(bus_w.full),   64'(tbl[i].full));
      check($sformatf("tbl%0d.done", i),   64'(bus_w.done),   64'(tbl[i].done));
      check($sformatf("tbl%0d.err", i),    64'(bus_w.err),    64'(tbl[i].err));
    end

    // full 1234, then press 9: WRAP=1 restarts, WRAP=0 rejects
    tick(4'd0, 0, 0, 1, 0);
    tick(4'd0, 0, 0, 0, 0);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    tick(4'd9, 1, 0, 0, 0);
    check("wrap1.digits", 64'(bus_w.digits), 64'h9FFF);
    check("wrap1.full",   64'(bus_w.full),   64'd0);
    check("wrap0.digits", 64'(bus_n.digits), 64'h1234);
    check("wrap0.err",    64'(bus_n.err),    64'd1);
    tick(4'd9, 0, 0, 0, 0);
    check("wrap0.err_clear", 64'(bus_n.err), 64'd0);

    // enter held for 10 cycles captures exactly one digit
    tick(4'd0, 0, 0, 1, 0);
    tick(4'd0, 0, 0, 0, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) tick(4'd6, 1, 0, 0, 0);
    check("held.count",  64'(bus_w.count),  64'd1);
    check("held.digits", 64'(bus_w.digits), 64'h6FFF);
    tick(4'd6, 0, 0, 0, 0);

    // reset mid-entry with enter held high
    press(4'd2);
    tick(4'd5, 1, 0, 0, 0);
    check("mid.count", 64'(bus_w.count), 64'd3);
    tick(4'd5, 1, 0, 0, 1);
    tick(4'd5, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(4'd5, 1, 0, 0, 0);
    check("rsthold.count",  64'(bus_w.count),  64'd0);
    check("rsthold.digits", 64'(bus_w.digits), 64'hFFFF);
    tick(4'd5, 0, 0, 0, 0);
    tick(4'd5, 1, 0, 0, 0);
    check("rsthold.repress", 64'(bus_w.digits), 64'h5FFF);
    tick(4'd5, 0, 0, 0, 0);

    // randomized traffic against the model; also count done pulses
    for (int i = 0; i < 600; i++) begin
      tick(4'($urandom_range(0, 11)), bit'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 79) == 0);
      if (bus_w.done) dones++;
      if (bus_w.done && bus_w.err) check("rand.done_err_excl", 64'd1, 64'd0);
    end
    $display("random phase done pulses (WRAP=1): %0d", dones);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
